digit_scan_decoder: RTL
=======================

DIGIT_SCAN_DECODER -- requirements
Module: digit_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4: consecutive identical cycles required before a digit is captured (range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535: cycles without any capture before link_lost is asserted (range 16..2^20-1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  decode enable; low freezes capture and timeout counting.
REQ-006 SHALL have port csn  input  4  sampled digit select, active-low, bit0 = single digit, bit3 = kilo digit.
REQ-007 SHALL have port abcdefg  input  7  sampled segment lines, active-high, bit6 = a, bit0 = g.
REQ-008 SHALL have port single_digit, ten_digit, hundred_digit, kilo_digit  output  4 each  last complete decoded frame.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when the four digit outputs update.
REQ-010 SHALL have port seg_err  output  1  one-cycle pulse when a stable pattern is not in the decode table.
REQ-011 SHALL have port sel_err  output  1  one-cycle pulse on the first cycle that more than one csn bit is low.
REQ-012 SHALL have port link_lost  output  1  level, high while no capture has occurred for TIMEOUT_CYC cycles.

Function
REQ-013 SHALL register csn and abcdefg once at input (1-cycle sample stage); all rules below apply to the sampled values.
REQ-014 SHALL classify each sampled csn as NONE (4'b1111), ONE (exactly one bit low, index k) or MULTI (two or more bits low).
REQ-015 SHALL increment a saturating stability counter when class is ONE and {csn,abcdefg} equals the previous sample, else clear it to 0.
REQ-016 SHALL capture digit k exactly once per select slot when the counter reaches STABLE_CYC-1; the slot ends when csn changes.
REQ-017 SHALL decode using the 16-entry hex table: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-018 SHALL treat a capture with a pattern absent from the table as invalid: pulse seg_err, store nothing, leave got[k] unchanged.
REQ-019 SHALL on a valid capture write shadow[k] and set got[k]; a repeated capture of k before frame completion overwrites shadow[k].
REQ-020 SHALL, in the cycle after got becomes 4'b1111, copy all shadow values to the digit outputs, pulse frame_valid and clear got.
REQ-021 SHALL pulse sel_err on entry to MULTI, clear the stability counter, and capture nothing while MULTI persists.
REQ-022 SHALL run a timeout counter that clears on every valid capture and saturates at TIMEOUT_CYC, with link_lost = (counter == TIMEOUT_CYC); link_lost drops in the cycle after the next valid capture.
REQ-023 SHALL, while en is low, hold got, shadow, outputs and the timeout counter, clear the stability counter, and suppress all pulses.
REQ-024 SHALL guarantee that frame_valid, seg_err and sel_err are never high for more than one consecutive cycle per triggering event.

Reset
REQ-025 SHALL on rst drive digit outputs to 4'h0, frame_valid, seg_err, sel_err and link_lost to 0, clear got, shadow, sample registers and all counters, and set the sampled csn to 4'b1111.
REQ-026 SHALL abandon any partially collected frame when rst is asserted mid-frame; no frame_valid follows reset until four new valid captures occur.

Structure
REQ-027 SHALL place the segment decode table, the digit-index constants and the NONE/ONE/MULTI class encoding in the shared display package used by the display driver.
REQ-028 SHALL implement table lookup as one combinational sub-module seg7_to_hex (7-bit in, 4-bit value and valid flag out).

Verification
REQ-029 SHALL hold csn=1110 with abcdefg=0110000, then 1101/1101101, 1011/1111001 and 0111/0110011, each for 6 cycles -> one frame_valid pulse; outputs single=1, ten=2, hundred=3, kilo=4.
REQ-030 SHALL hold a slot for only STABLE_CYC-1 identical cycles -> no capture and no frame_valid.
REQ-031 SHALL apply stable abcdefg=0000001 on csn=1110 -> single seg_err pulse; got unchanged.
REQ-032 SHALL drive csn=1100 for 10 cycles -> exactly one sel_err pulse and no capture.
REQ-033 SHALL use TIMEOUT_CYC=16 and hold csn=1111 -> link_lost high at cycle 16, then low one cycle after the next valid capture.
REQ-034 SHALL assert rst after 3 digits are captured, then send 4 digits -> exactly one frame_valid carrying only the post-reset values.

Source files
------------

// File: rtl/digit_scan_decoder_pkg.sv
// Shared display package: segment decode table, digit slot indices and
// digit-select classification used by the scan decoder and display driver.
package digit_scan_decoder_pkg;

   // Digit slot indices, matching csn bit positions.
   localparam int unsigned DigitSingle  = 0;
   localparam int unsigned DigitTen     = 1;
   localparam int unsigned DigitHundred = 2;
   localparam int unsigned DigitKilo    = 3;

   // Segment patterns for hex values 0..F, bit6 = a ... bit0 = g.
   localparam logic [6:0] SegTable [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   // Digit-select classification of one sampled csn value.
   typedef enum logic [1:0] {
      SelNone,
      SelOne,
      SelMulti
   } sel_class_e;

   function automatic sel_class_e classify_sel(logic [3:0] csn);
      logic [2:0] lows;
      lows = '0;
      for (int i = 0; i < 4; i++) begin
         lows = lows + {2'b00, ~csn[i]};
      end
      if (lows == 3'd0) begin
         return SelNone;
      end else if (lows == 3'd1) begin
         return SelOne;
      end else begin
         return SelMulti;
      end
   endfunction

   // Index of the low csn bit; only meaningful when the class is SelOne.
   function automatic logic [1:0] sel_index(logic [3:0] csn);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (!csn[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/digit_scan_decoder_seg7_to_hex.sv
// Combinational 7-segment pattern to hex value lookup with a match flag.
module seg7_to_hex
   import digit_scan_decoder_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] value,
   output logic       valid
);

   // Search the shared table; valid stays low for patterns it does not hold.
   always_comb begin
      value = '0;
      valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SegTable[i]) begin
            value = 4'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/digit_scan_decoder.sv
// Decodes a multiplexed 4-digit 7-segment scan into four hex digits,
// with stability filtering, frame assembly, error pulses and link timeout.
module digit_scan_decoder
   import digit_scan_decoder_pkg::*;
#(
   parameter int unsigned STABLE_CYC  = 4,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] csn,
   input  logic [6:0] abcdefg,
   output logic [3:0] single_digit,
   output logic [3:0] ten_digit,
   output logic [3:0] hundred_digit,
   output logic [3:0] kilo_digit,
   output logic       frame_valid,
   output logic       seg_err,
   output logic       sel_err,
   output logic       link_lost
);

   localparam logic [7:0]  StableLast = 8'(STABLE_CYC - 1);
   localparam logic [7:0]  StableHit  = 8'(STABLE_CYC - 2);
   localparam logic [19:0] TimeoutMax = 20'(TIMEOUT_CYC);

   logic [3:0]       csn_q, csn_p_q;
   logic [6:0]       seg_q, seg_p_q;
   logic [7:0]       stab_q, stab_d;
   logic             taken_q, taken_d;
   logic [3:0]       got_q, got_d;
   logic [3:0][3:0]  shadow_q, shadow_d;
   logic [3:0][3:0]  digits_q, digits_d;
   logic             frame_valid_q, frame_valid_d;
   logic             seg_err_q, seg_err_d;
   logic             sel_err_q, sel_err_d;
   logic [19:0]      timeout_q, timeout_d;

   sel_class_e cls_cur, cls_prev;
   logic       same, stab_inc, cap, cap_ok, cap_bad;
   logic [1:0] dig_idx;
   logic [3:0] dec_value;
   logic       dec_valid;

   seg7_to_hex u_seg7_to_hex (
      .seg   (seg_q),
      .value (dec_value),
      .valid (dec_valid)
   );

   assign cls_cur  = classify_sel(csn_q);
   assign cls_prev = classify_sel(csn_p_q);
   assign dig_idx  = sel_index(csn_q);
   assign same     = (csn_q == csn_p_q) && (seg_q == seg_p_q);
   assign stab_inc = en && (cls_cur == SelOne) && same;
   // Capture fires on the step that brings the counter to STABLE_CYC-1, once per slot.
   assign cap      = stab_inc && (stab_q == StableHit) && !taken_q;
   assign cap_ok   = cap && dec_valid;
   assign cap_bad  = cap && !dec_valid;

   // Input sample stage plus one-deep history for the stability compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csn_q   <= 4'b1111;
         seg_q   <= '0;
         csn_p_q <= 4'b1111;
         seg_p_q <= '0;
      end else begin
         csn_q   <= csn;
         seg_q   <= abcdefg;
         csn_p_q <= csn_q;
         seg_p_q <= seg_q;
      end
   end

   // Next-state for stability, frame assembly, pulses and timeout.
   always_comb begin
      stab_d        = '0;
      taken_d       = (csn_q != csn_p_q) ? 1'b0 : taken_q;
      got_d         = got_q;
      shadow_d      = shadow_q;
      digits_d      = digits_q;
      frame_valid_d = 1'b0;
      seg_err_d     = 1'b0;
      sel_err_d     = 1'b0;
      timeout_d     = timeout_q;
      if (stab_inc) begin
         stab_d = (stab_q == StableLast) ? stab_q : stab_q + 8'd1;
      end
      if (cap) begin
         taken_d = 1'b1;
      end
      if (en) begin
         // Publish the previous cycle's complete frame before recording a new capture.
         if (got_q == 4'b1111) begin
            digits_d      = shadow_q;
            frame_valid_d = 1'b1;
            got_d         = '0;
         end
         if (cap_ok) begin
            got_d[dig_idx]    = 1'b1;
            shadow_d[dig_idx] = dec_value;
         end
         seg_err_d = cap_bad;
         sel_err_d = (cls_cur == SelMulti) && (cls_prev != SelMulti);
         if (cap_ok) begin
            timeout_d = '0;
         end else if (timeout_q != TimeoutMax) begin
            timeout_d = timeout_q + 20'd1;
         end
      end
   end

   // State registers for the decode path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stab_q        <= '0;
         taken_q       <= 1'b0;
         got_q         <= '0;
         shadow_q      <= '0;
         digits_q      <= '0;
         frame_valid_q <= 1'b0;
         seg_err_q     <= 1'b0;
         sel_err_q     <= 1'b0;
         timeout_q     <= '0;
      end else begin
         stab_q        <= stab_d;
         taken_q       <= taken_d;
         got_q         <= got_d;
         shadow_q      <= shadow_d;
         digits_q      <= digits_d;
         frame_valid_q <= frame_valid_d;
         seg_err_q     <= seg_err_d;
         sel_err_q     <= sel_err_d;
         timeout_q     <= timeout_d;
      end
   end

   assign single_digit  = digits_q[DigitSingle];
   assign ten_digit     = digits_q[DigitTen];
   assign hundred_digit = digits_q[DigitHundred];
   assign kilo_digit    = digits_q[DigitKilo];
   assign frame_valid   = frame_valid_q;
   assign seg_err       = seg_err_q;
   assign sel_err       = sel_err_q;
   assign link_lost     = (timeout_q == TimeoutMax);

endmodule
